// File: rtl/sysid_checker_pkg.sv
// +----------------------------------------------------------------------+
// | sysid_checker_pkg : shared encodings for the boot-time sysid checker |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package sysid_checker_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_ID = 2'd1,
        RD_TS = 2'd2,
        CHECK = 2'd3
    } state_e;

    localparam logic [1:0] FAIL_NONE    = 2'd0;
    localparam logic [1:0] FAIL_ID      = 2'd1;
    localparam logic [1:0] FAIL_TS      = 2'd2;
    localparam logic [1:0] FAIL_TIMEOUT = 2'd3;

    localparam logic ADDR_ID = 1'b0;
    localparam logic ADDR_TS = 1'b1;

    function automatic logic is_read_state(input state_e s);
        return (s == RD_ID) || (s == RD_TS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sysid_timeout_counter.sv
// +----------------------------------------------------------------------+
// | sysid_timeout_counter : 16-bit clear/enable stall counter with       |
// | terminal-count compare                                               |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sysid_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [15:0] TERMINAL = 16'(TIMEOUT_CYCLES);

    logic [15:0] count_q;
    logic [15:0] count_d;

    // Saturates so a stuck enable can never wrap back below the terminal count.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == TERMINAL);

endmodule

`default_nettype wire

// File: rtl/sysid_boot_checker.sv
// +----------------------------------------------------------------------+
// | sysid_boot_checker : Avalon-MM read master that verifies the system  |
// | ID and timestamp words at boot, with retry and stall timeout         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module sysid_boot_checker
    import sysid_checker_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1457698467,
    parameter int unsigned MAX_RETRIES        = 3,
    parameter int unsigned TIMEOUT_CYCLES     = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [3:0]  retries_used,
    output logic [31:0] id_seen,
    output logic [31:0] timestamp_seen,
    output logic        sysid_address,
    output logic        sysid_read,
    input  logic        sysid_waitrequest,
    input  logic [31:0] sysid_readdata
);

    localparam logic [3:0] MAX_R = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic [1:0]  fail_code_q, fail_code_d;
    logic [3:0]  retries_q, retries_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;

    logic w_expired;
    logic w_cnt_clear;
    logic w_cnt_enable;
    logic w_id_ok;
    logic w_ts_ok;
    logic w_can_retry;

    assign w_id_ok     = (id_q == EXPECTED_ID);
    assign w_ts_ok     = (ts_q == EXPECTED_TIMESTAMP);
    assign w_can_retry = (retries_q < MAX_R);

    // Every state change (including an accept) restarts the stall count.
    assign w_cnt_clear  = (state_d != state_q) || !is_read_state(state_q);
    assign w_cnt_enable = is_read_state(state_q) && sysid_waitrequest;

    sysid_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_i   (w_cnt_clear),
        .enable_i  (w_cnt_enable),
        .expired_o (w_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RD_ID;
            RD_ID: begin
                if (w_expired)               state_d = IDLE;
                else if (!sysid_waitrequest) state_d = RD_TS;
            end
            RD_TS: begin
                if (w_expired)               state_d = IDLE;
                else if (!sysid_waitrequest) state_d = CHECK;
            end
            CHECK: begin
                if (w_id_ok && w_ts_ok) state_d = IDLE;
                else if (w_can_retry)   state_d = RD_ID;
                else                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_code_d = fail_code_q;
        retries_d   = retries_q;
        id_d        = id_q;
        ts_d        = ts_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    pass_d      = 1'b0;
                    fail_code_d = FAIL_NONE;
                    retries_d   = '0;
                end
            end
            RD_ID: begin
                if (w_expired) begin
                    done_d      = 1'b1;
                    fail_code_d = FAIL_TIMEOUT;
                end else if (!sysid_waitrequest) begin
                    id_d = sysid_readdata;
                end
            end
            RD_TS: begin
                if (w_expired) begin
                    done_d      = 1'b1;
                    fail_code_d = FAIL_TIMEOUT;
                end else if (!sysid_waitrequest) begin
                    ts_d = sysid_readdata;
                end
            end
            CHECK: begin
                if (w_id_ok && w_ts_ok) begin
                    done_d      = 1'b1;
                    pass_d      = 1'b1;
                    fail_code_d = FAIL_NONE;
                end else if (w_can_retry) begin
                    retries_d = retries_q + 4'd1;
                end else begin
                    done_d      = 1'b1;
                    fail_code_d = w_id_ok ? FAIL_TS : FAIL_ID;
                end
            end
            default: done_d = 1'b0;
        endcase
        read_d = is_read_state(state_d);
        addr_d = (state_d == RD_TS) ? ADDR_TS : ADDR_ID;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FAIL_NONE;
            retries_q   <= '0;
            id_q        <= '0;
            ts_q        <= '0;
            read_q      <= 1'b0;
            addr_q      <= ADDR_ID;
        end else begin
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_code_q <= fail_code_d;
            retries_q   <= retries_d;
            id_q        <= id_d;
            ts_q        <= ts_d;
            read_q      <= read_d;
            addr_q      <= addr_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign fail_code      = fail_code_q;
    assign retries_used   = retries_q;
    assign id_seen        = id_q;
    assign timestamp_seen = ts_q;
    assign sysid_read     = read_q;
    assign sysid_address  = addr_q;

endmodule

`default_nettype wire

// File: tb/tb_sysid_boot_checker.sv
// +----------------------------------------------------------------------+
// | tb_sysid_boot_checker : vector table plus corner sequences against   |
// | an Avalon sysid slave model, results checked through a scoreboard    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_sysid_boot_checker;

    localparam logic [31:0] TS_OK  = 32'd1457698467;
    localparam logic [31:0] TS_BAD = 32'hDEADBEEF;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic        busy, done, pass;
    logic [1:0]  fail_code;
    logic [3:0]  retries_used;
    logic [31:0] id_seen, timestamp_seen;
    logic        sysid_address, sysid_read, sysid_waitrequest;
    logic [31:0] sysid_readdata;

    sysid_boot_checker #(
        .EXPECTED_ID        (32'd0),
        .EXPECTED_TIMESTAMP (TS_OK),
        .MAX_RETRIES        (3),
        .TIMEOUT_CYCLES     (8)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .fail_code         (fail_code),
        .retries_used      (retries_used),
        .id_seen           (id_seen),
        .timestamp_seen    (timestamp_seen),
        .sysid_address     (sysid_address),
        .sysid_read        (sysid_read),
        .sysid_waitrequest (sysid_waitrequest),
        .sysid_readdata    (sysid_readdata)
    );

    always #5 clock = ~clock;

    // Slave model: bad ID for the first m_bad reads of address 0, m_wait stall cycles per read.
    int          m_bad   = 0;
    logic [31:0] m_ts    = TS_OK;
    int          m_wait  = 0;
    bit          m_stuck = 1'b0;
    int          m_idreads = 0;
    int          m_wcnt    = 0;
    int          cyc       = 0;

    assign sysid_waitrequest = m_stuck | (sysid_read & (m_wcnt < m_wait));
    assign sysid_readdata    = sysid_address ? m_ts : ((m_idreads < m_bad) ? 32'h1 : 32'h0);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (sysid_read && sysid_waitrequest) m_wcnt <= m_wcnt + 1;
        else                                 m_wcnt <= 0;
        if (start && !busy)                                         m_idreads <= 0;
        else if (sysid_read && !sysid_waitrequest && !sysid_address) m_idreads <= m_idreads + 1;
    end

    typedef struct {
        bit          e_pass;
        logic [1:0]  e_code;
        logic [3:0]  e_ret;
        logic [31:0] e_id;
        logic [31:0] e_ts;
        int          e_lat;
        int          start_cyc;
    } exp_t;

    typedef struct {
        int          bad;
        logic [31:0] ts;
        int          wait_n;
        bit          e_pass;
        logic [1:0]  e_code;
        logic [3:0]  e_ret;
        logic [31:0] e_id;
        logic [31:0] e_ts;
        int          e_lat;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   n_done   = 0;
    int   exp_done = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(negedge clock) begin
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
            end else begin
                mon_e = sb.pop_front();
                check("pass",         {31'd0, pass},  {31'd0, mon_e.e_pass});
                check("fail_code",    {30'd0, fail_code}, {30'd0, mon_e.e_code});
                check("retries_used", {28'd0, retries_used}, {28'd0, mon_e.e_ret});
                check("id_seen",      id_seen, mon_e.e_id);
                check("timestamp_seen", timestamp_seen, mon_e.e_ts);
                check("latency",      32'(cyc - mon_e.start_cyc + 1), 32'(mon_e.e_lat));
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Caller is at a negedge; start_cyc is the cycle count after the sampling edge.
    task automatic push_exp(input bit p, input logic [1:0] c, input logic [3:0] r,
                            input logic [31:0] id, input logic [31:0] ts, input int lat);
        exp_t e;
        e.e_pass = p; e.e_code = c; e.e_ret = r; e.e_id = id; e.e_ts = ts;
        e.e_lat = lat; e.start_cyc = cyc + 1;
        sb.push_back(e);
        exp_done++;
    endtask

    task automatic wait_empty(input string name);
        for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clock);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL %s_timeout: got %0d pending results, expected 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_pass"},  {31'd0, pass}, 32'd0);
        check({tag, "_code"},  {30'd0, fail_code}, 32'd0);
        check({tag, "_ret"},   {28'd0, retries_used}, 32'd0);
        check({tag, "_id"},    id_seen, 32'd0);
        check({tag, "_ts"},    timestamp_seen, 32'd0);
        check({tag, "_read"},  {31'd0, sysid_read}, 32'd0);
        check({tag, "_addr"},  {31'd0, sysid_address}, 32'd0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{0,  TS_OK,  0, 1'b1, 2'd0, 4'd0, 32'h0, TS_OK,  4};
        vecs[1] = '{2,  TS_OK,  0, 1'b1, 2'd0, 4'd2, 32'h0, TS_OK,  10};
        vecs[2] = '{0,  TS_BAD, 0, 1'b0, 2'd2, 4'd3, 32'h0, TS_BAD, 13};
        vecs[3] = '{0,  TS_OK,  2, 1'b1, 2'd0, 4'd0, 32'h0, TS_OK,  8};
        vecs[4] = '{15, TS_BAD, 0, 1'b0, 2'd1, 4'd3, 32'h1, TS_BAD, 13};
        vecs[5] = '{3,  TS_OK,  0, 1'b1, 2'd0, 4'd3, 32'h0, TS_OK,  13};
        vecs[6] = '{4,  TS_OK,  0, 1'b0, 2'd1, 4'd3, 32'h1, TS_OK,  13};

        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            m_bad = vecs[i].bad; m_ts = vecs[i].ts; m_wait = vecs[i].wait_n; m_stuck = 1'b0;
            start = 1'b1;
            push_exp(vecs[i].e_pass, vecs[i].e_code, vecs[i].e_ret, vecs[i].e_id, vecs[i].e_ts, vecs[i].e_lat);
            @(negedge clock);
            start = 1'b0;
            wait_empty($sformatf("vec%0d", i));
            @(negedge clock);
        end

        // Nominal cycle-exact read sequence, then start in the done cycle.
        m_bad = 0; m_ts = TS_OK; m_wait = 0;
        start = 1'b1;
        push_exp(1'b1, 2'd0, 4'd0, 32'h0, TS_OK, 4);
        @(negedge clock); start = 1'b0;
        check("seq_c1_read", {31'd0, sysid_read}, 32'd1);
        check("seq_c1_addr", {31'd0, sysid_address}, 32'd0);
        check("seq_c1_busy", {31'd0, busy}, 32'd1);
        @(negedge clock);
        check("seq_c2_read", {31'd0, sysid_read}, 32'd1);
        check("seq_c2_addr", {31'd0, sysid_address}, 32'd1);
        @(negedge clock);
        check("seq_c3_read", {31'd0, sysid_read}, 32'd0);
        check("seq_c3_busy", {31'd0, busy}, 32'd1);
        check("seq_c3_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        check("seq_c4_done", {31'd0, done}, 32'd1);
        start = 1'b1;
        push_exp(1'b1, 2'd0, 4'd0, 32'h0, TS_OK, 4);
        @(negedge clock); start = 1'b0;
        check("b2b_read", {31'd0, sysid_read}, 32'd1);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_empty("b2b");

        // Stalled slave: abort after TIMEOUT_CYCLES, no retry.
        @(negedge clock);
        m_stuck = 1'b1;
        start = 1'b1;
        push_exp(1'b0, 2'd3, 4'd0, 32'h0, TS_OK, 10);
        @(negedge clock); start = 1'b0;
        repeat (8) @(negedge clock);
        check("tmo_c9_read", {31'd0, sysid_read}, 32'd1);
        check("tmo_c9_done", {31'd0, done}, 32'd0);
        @(negedge clock);
        check("tmo_c10_read", {31'd0, sysid_read}, 32'd0);
        check("tmo_c10_done", {31'd0, done}, 32'd1);
        wait_empty("tmo");
        repeat (5) @(negedge clock);
        check("tmo_no_retry_read", {31'd0, sysid_read}, 32'd0);
        m_stuck = 1'b0;

        // Start while busy must be ignored.
        m_wait = 2;
        start = 1'b1;
        push_exp(1'b1, 2'd0, 4'd0, 32'h0, TS_OK, 8);
        @(negedge clock); start = 1'b0;
        repeat (2) @(negedge clock);
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        wait_empty("ignore");
        repeat (15) @(negedge clock);
        check("ignore_idle_busy", {31'd0, busy}, 32'd0);
        m_wait = 0;

        // Reset during RD_TS.
        start = 1'b1;
        @(negedge clock); start = 1'b0;
        @(negedge clock);
        check("rst_pre_addr", {31'd0, sysid_address}, 32'd1);
        check("rst_pre_read", {31'd0, sysid_read}, 32'd1);
        reset_n = 1'b0;
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        check("midrst_after_busy", {31'd0, busy}, 32'd0);

        check("done_count", 32'(n_done), 32'(exp_done));
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sysid_boot_checker.md
# sysid_boot_checker

Boot-time identity checker that acts as an Avalon-MM read master on the system ID peripheral's control slave. On a `start` pulse it reads the ID word (address 0) and the timestamp word (address 1), then compares both against build-time expected values. It retries the whole sequence on mismatch and aborts on a stalled slave. It sits beside the Nios II system and gates software/hardware start-up with a single `pass` flag and a failure code.

## Interface
- `EXPECTED_ID`, default 32'd0: required value at address 0.
- `EXPECTED_TIMESTAMP`, default 32'd1457698467: required value at address 1.
- `MAX_RETRIES`, default 3: full re-read attempts after a mismatch (0..15).
- `TIMEOUT_CYCLES`, default 255: consecutive waitrequest-high cycles before abort (1..65535).

- `clock`  in  1  system clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to run a check; ignored while `busy`.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse when the check completes.
- `pass`  out  1  result level, valid from `done` until the next accepted `start`.
- `fail_code`  out  2  0 none, 1 ID mismatch, 2 timestamp mismatch, 3 timeout.
- `retries_used`  out  4  number of retries consumed by the last run.
- `id_seen`  out  32  last captured address-0 word.
- `timestamp_seen`  out  32  last captured address-1 word.
- `sysid_address`  out  1  Avalon master address.
- `sysid_read`  out  1  Avalon read strobe.
- `sysid_waitrequest`  in  1  slave stall; a 0-wait slave ties this to 0.
- `sysid_readdata`  in  32  read data, sampled on the edge where `sysid_read`=1 and `sysid_waitrequest`=0.

## Operation
- FSM states:
  - IDLE: `start` → RD_ID; clear `pass`, `fail_code`, `retries_used`, and the retry and timeout counters.
  - RD_ID: `sysid_read`=1, `sysid_address`=0. Accept → capture `id_seen` → RD_TS.
  - RD_TS: `sysid_read`=1, `sysid_address`=1. Accept → capture `timestamp_seen` → CHECK.
  - CHECK: compare both captured words. ID is checked first, so if both mismatch, code=1.
    - Match → IDLE with `done`=1, `pass`=1, code 0.
    - Mismatch with retry count < `MAX_RETRIES` → RD_ID, retry count +1.
    - Mismatch with retries exhausted → IDLE with `done`=1, `pass`=0, code 1 or 2.
- Timeout:
  - A 16-bit counter increments each RD_* cycle in which `sysid_waitrequest`=1.
  - It clears on every accept and on state entry.
  - When it reaches `TIMEOUT_CYCLES`, drop `sysid_read` and go to IDLE with `done`=1, `pass`=0, code 3. Timeouts are never retried.
- `sysid_read` and `sysid_address` are registered outputs: `sysid_read` is high only in RD_ID/RD_TS, and address is 0 outside RD_TS.
- `retries_used` mirrors the retry counter and holds after `done`.
- `start` asserted in the same cycle as `done` is accepted, because the FSM is already in IDLE at that edge → a new run begins.

## Timing
- Reset value of every output is 0: `busy`, `done`, `pass`, `fail_code`, `retries_used`, `id_seen`, `timestamp_seen`, `sysid_address`, `sysid_read`.
- Reset mid-operation drops `sysid_read` asynchronously, and no `done` is generated.
- Zero-wait slave, `start` sampled at edge 0:
  - edge 1: RD_ID.
  - edge 2: RD_TS.
  - edge 3: CHECK.
  - edge 4: `done`=1 and `pass` valid.
  - Minimum latency is therefore 4 cycles.
- Each waitrequest cycle adds one cycle.
- Each retry adds 3 cycles (RD_ID, RD_TS, CHECK).
- Timeout `done` is registered `TIMEOUT_CYCLES`+1 edges after entering the stalled read state.
- `busy` is 1 in RD_ID, RD_TS and CHECK, and 0 in the cycle `done` is high.

## Structure
- Package `sysid_checker_pkg`:
  - state encoding: IDLE, RD_ID, RD_TS, CHECK;
  - fail-code constants FAIL_NONE, FAIL_ID, FAIL_TS, FAIL_TIMEOUT;
  - Avalon address constants ADDR_ID=0, ADDR_TS=1.
- One sub-module, `sysid_timeout_counter`: a 16-bit clear/enable counter with a terminal-count compare against `TIMEOUT_CYCLES`. Everything else lives in the top FSM.

## Test plan
- Zero-wait model returning 0 / 1457698467, `start` pulse → `done` 4 cycles later, `pass`=1, code 0, `retries_used`=0, address sequence 0 then 1.
- Model returns ID 0x1 on the first two passes, then 0 → `pass`=1, `retries_used`=2, `done` at cycle 10.
- Model always returns timestamp 0xDEADBEEF, `MAX_RETRIES`=3 → `pass`=0, code 2, `retries_used`=3, `timestamp_seen`=0xDEADBEEF.
- `waitrequest` stuck high, `TIMEOUT_CYCLES`=8 → `sysid_read` drops and `done` is registered 9 edges after entering RD_ID, code 3, no retry.
- Waitrequest high for 2 cycles on each read → `done` at cycle 8, `pass`=1; `start` pulsed while `busy` is ignored.
- `reset_n` asserted during RD_TS → all outputs 0 immediately, FSM returns to IDLE, and no `done` pulse after release.
